// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet-train generator.
package axis_pkt_gen_pkg;

  typedef enum logic [1:0] {IDLE, DATA, GAP, DONE} state_e;

  localparam logic MODE_INC   = 1'b0;
  localparam logic MODE_CONST = 1'b1;

endpackage

// File: rtl/axis_pkt_gen_cnt.sv
// Loadable saturating down-counter with zero flag; used for beats, packets and gap.
module axis_pkt_gen_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                       cnt_q <= '0;
    else if (load_i)               cnt_q <= val_i;
    else if (dec_i && !zero_o)     cnt_q <= cnt_q - W'(1);
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream master: one send pulse emits pkt_cnt packets of pkt_len beats with gap idle cycles between.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 8,
  parameter int GAP_W  = 4
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              send,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [CNT_W-1:0]  pkt_cnt,
  input  logic [GAP_W-1:0]  gap,
  input  logic [DATA_W-1:0] seed,
  input  logic              mode,
  input  logic              tready,
  output logic              tvalid,
  output logic [DATA_W-1:0] tdata,
  output logic              tlast,
  output logic              tuser,
  output logic              busy,
  output logic              finish
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                mode_q, mode_d;
  logic                tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                busy_q, busy_d, finish_q, finish_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d, nxt_data;

  // Beat counter holds beats remaining after the one on the bus.
  logic                beat_ld, beat_dec, beat_zero_unused;
  logic [LEN_W-1:0]    beat_val, beat_cnt;
  logic                pkt_ld, pkt_dec, pkt_zero;
  logic [CNT_W-1:0]    pkt_val, pkt_cnt_unused;
  logic                gap_ld, gap_dec, gap_zero;
  logic [GAP_W-1:0]    gap_val, gap_cnt_unused;

  logic hs;
  assign hs       = tvalid_q & tready;
  assign nxt_data = (mode_q == MODE_CONST) ? tdata_q : tdata_q + DATA_W'(1);

  axis_pkt_gen_cnt #(.W(LEN_W)) u_beat (
    .clk(aclk), .rst(rst), .load_i(beat_ld), .val_i(beat_val), .dec_i(beat_dec),
    .cnt_o(beat_cnt), .zero_o(beat_zero_unused));

  axis_pkt_gen_cnt #(.W(CNT_W)) u_pkt (
    .clk(aclk), .rst(rst), .load_i(pkt_ld), .val_i(pkt_val), .dec_i(pkt_dec),
    .cnt_o(pkt_cnt_unused), .zero_o(pkt_zero));

  axis_pkt_gen_cnt #(.W(GAP_W)) u_gap (
    .clk(aclk), .rst(rst), .load_i(gap_ld), .val_i(gap_val), .dec_i(gap_dec),
    .cnt_o(gap_cnt_unused), .zero_o(gap_zero));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    gap_d    = gap_q;
    mode_d   = mode_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    busy_d   = busy_q;
    finish_d = 1'b0;
    beat_ld  = 1'b0;
    beat_dec = 1'b0;
    beat_val = '0;
    pkt_ld   = 1'b0;
    pkt_dec  = 1'b0;
    pkt_val  = '0;
    gap_ld   = 1'b0;
    gap_dec  = 1'b0;
    gap_val  = '0;
    case (state_q)
      IDLE: if (send && pkt_len != '0 && pkt_cnt != '0) begin
        state_d  = DATA;
        len_d    = pkt_len;
        gap_d    = gap;
        mode_d   = mode;
        tdata_d  = seed;
        tvalid_d = 1'b1;
        tuser_d  = 1'b1;
        tlast_d  = (pkt_len == LEN_W'(1));
        busy_d   = 1'b1;
        beat_ld  = 1'b1;
        beat_val = pkt_len - LEN_W'(1);
        pkt_ld   = 1'b1;
        pkt_val  = pkt_cnt - CNT_W'(1);
      end
      DATA: if (hs) begin
        tdata_d = nxt_data;
        if (!tlast_q) begin
          beat_dec = 1'b1;
          tuser_d  = 1'b0;
          tlast_d  = (beat_cnt == LEN_W'(1));
        end else if (pkt_zero) begin
          state_d  = DONE;
          tvalid_d = 1'b0;
          tuser_d  = 1'b0;
          tlast_d  = 1'b0;
          busy_d   = 1'b0;
          finish_d = 1'b1;
        end else begin
          // Next packet's first beat is staged now; GAP only delays tvalid.
          pkt_dec  = 1'b1;
          beat_ld  = 1'b1;
          beat_val = len_q - LEN_W'(1);
          tuser_d  = 1'b1;
          tlast_d  = (len_q == LEN_W'(1));
          if (gap_q != '0) begin
            state_d  = GAP;
            tvalid_d = 1'b0;
            gap_ld   = 1'b1;
            gap_val  = gap_q - GAP_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_zero) begin
          state_d  = DATA;
          tvalid_d = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      gap_q    <= '0;
      mode_q   <= MODE_INC;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      mode_q   <= mode_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  assign tvalid = tvalid_q;
  assign tdata  = tdata_q;
  assign tlast  = tlast_q;
  assign tuser  = tuser_q;
  assign busy   = busy_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: expected beats queued at send, popped at handshake.
module tb_axis_pkt_gen;
  localparam int DATA_W = 32, LEN_W = 8, CNT_W = 8, GAP_W = 4;

  logic              aclk = 1'b0, rst = 1'b1, send = 1'b0, mode = 1'b0, tready = 1'b1;
  logic [LEN_W-1:0]  pkt_len = '0;
  logic [CNT_W-1:0]  pkt_cnt = '0;
  logic [GAP_W-1:0]  gap = '0;
  logic [DATA_W-1:0] seed = '0;
  logic              tvalid, tlast, tuser, busy, finish;
  logic [DATA_W-1:0] tdata;

  axis_pkt_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .aclk(aclk), .rst(rst), .send(send), .pkt_len(pkt_len), .pkt_cnt(pkt_cnt),
    .gap(gap), .seed(seed), .mode(mode), .tready(tready), .tvalid(tvalid),
    .tdata(tdata), .tlast(tlast), .tuser(tuser), .busy(busy), .finish(finish));

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              u;
    logic              l;
  } exp_t;

  exp_t sb[$];
  int   hs_t[$];
  int   n_tests = 0, n_fail = 0, cyc = 0, hs_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Monitor: hold-under-stall checks and scoreboard pops on handshake.
  initial begin
    logic              stall = 1'b0, st_u = 1'b0, st_l = 1'b0;
    logic [DATA_W-1:0] st_d = '0;
    exp_t              e;
    forever begin
      @(negedge aclk);
      if (rst) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        chk("hold_vld", tvalid, 1);
        chk("hold_data", tdata, st_d);
        chk("hold_flags", {tuser, tlast}, {st_u, st_l});
      end
      stall = tvalid && !tready;
      st_d  = tdata;
      st_u  = tuser;
      st_l  = tlast;
      if (tvalid && tready) begin
        hs_cnt++;
        hs_t.push_back(cyc);
        if (sb.size() == 0) chk("unexp_beat", 1, 0);
        else begin
          e = sb.pop_front();
          chk("tdata", tdata, e.d);
          chk("tuser", tuser, e.u);
          chk("tlast", tlast, e.l);
        end
      end
    end
  end

  task automatic send_train(input int len, input int cnt, input int gp,
                            input logic [DATA_W-1:0] sd, input logic md);
    logic [DATA_W-1:0] d;
    exp_t e;
    bit   acc;
    acc = (len != 0) && (cnt != 0);
    @(posedge aclk); #1;
    pkt_len = LEN_W'(len); pkt_cnt = CNT_W'(cnt); gap = GAP_W'(gp); seed = sd; mode = md;
    send = 1'b1;
    d = sd;
    if (acc)
      for (int p = 0; p < cnt; p++)
        for (int b = 0; b < len; b++) begin
          e.d = d; e.u = (b == 0); e.l = (b == len - 1);
          sb.push_back(e);
          if (!md) d = d + 1;
        end
    @(posedge aclk); #1;
    send = 1'b0;
    pkt_len = LEN_W'($urandom); pkt_cnt = CNT_W'($urandom); gap = GAP_W'($urandom);
    seed = $urandom; mode = 1'($urandom);
    if (acc) begin
      chk("lat_vld", tvalid, 1);
      chk("lat_user", tuser, 1);
      chk("lat_data", tdata, sd);
      chk("lat_busy", busy, 1);
    end else begin
      chk("rej_busy", busy, 0);
      chk("rej_vld", tvalid, 0);
    end
  endtask

  task automatic wait_fin(input int budget, output int fcyc);
    bit got = 0;
    fcyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (finish) begin got = 1; fcyc = cyc; break; end
    end
    chk("finish_seen", got, 1);
    if (got) begin
      chk("fin_busy", busy, 0);
      @(negedge aclk);
      chk("fin_pulse", finish, 0);
      chk("idle_busy", busy, 0);
      chk("sb_empty", sb.size(), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc, base, nfin;
    bit done;
    // reset state
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    chk("rst_out", {tvalid, tlast, tuser, busy, finish}, 5'b0);
    chk("rst_data", tdata, 0);
    @(posedge aclk); #1 rst = 1'b0;

    // single packet
    send_train(4, 1, 0, 32'h10, 1'b0);
    wait_fin(40, fc);
    chk("fin_after_last", fc - hs_t[hs_t.size()-1], 1);

    // long stall before first handshake, then 1,0,1
    tready = 1'b0;
    send_train(40, 1, 0, 32'h1000, 1'b0);
    repeat (29) @(posedge aclk);
    #1 tready = 1'b1;
    @(posedge aclk); #1 tready = 1'b0;
    @(posedge aclk); #1 tready = 1'b1;
    wait_fin(200, fc);

    // three packets with gap, data wraps
    base = hs_t.size();
    send_train(2, 3, 2, 32'hFFFF_FFFE, 1'b0);
    wait_fin(60, fc);
    chk("pkt_beats", hs_t.size() - base, 6);
    if (hs_t.size() - base == 6) begin
      chk("in_pkt", hs_t[base+1] - hs_t[base], 1);
      chk("gap1", hs_t[base+2] - hs_t[base+1], 3);
      chk("gap2", hs_t[base+4] - hs_t[base+3], 3);
    end

    // zero gap, back-to-back single-beat packets, constant data
    base = hs_t.size();
    send_train(1, 2, 0, 32'hA5, 1'b1);
    wait_fin(40, fc);
    chk("b2b_beats", hs_t.size() - base, 2);
    if (hs_t.size() - base == 2) chk("b2b_gap", hs_t[base+1] - hs_t[base], 1);

    // rejected sends
    send_train(0, 3, 0, 32'h1, 1'b0);
    send_train(3, 0, 0, 32'h2, 1'b0);
    done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      if (finish || tvalid || busy) done = 1;
    end
    chk("rej_quiet", done, 0);

    // send while busy has no effect
    send_train(4, 2, 1, 32'h55, 1'b0);
    @(posedge aclk); #1;
    send = 1'b1; pkt_len = 9; pkt_cnt = 5; seed = 32'hDEAD; mode = 1'b1;
    @(posedge aclk); #1 send = 1'b0;
    wait_fin(80, fc);

    // reset mid-packet at beat 3 of 8
    base = hs_cnt;
    send_train(8, 1, 0, 32'h300, 1'b0);
    done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk); #1;
      if (hs_cnt >= base + 3) begin done = 1; break; end
    end
    chk("mid_reach", done, 1);
    @(posedge aclk); #1 rst = 1'b1;
    @(posedge aclk); #1;
    chk("mid_rst_vld", tvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fin", finish, 0);
    sb.delete();
    rst = 1'b0;
    nfin = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      if (finish) nfin++;
    end
    chk("mid_no_fin", nfin, 0);
    send_train(3, 1, 0, 32'h77, 1'b0);
    wait_fin(40, fc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
